// File: rtl/mult_8bits_seq.sv
// Sequential 8x8 unsigned shift-add multiplier with a start/busy/done handshake.
// One ripple-carry adder is reused across eight add/shift steps to form the 16-bit product.

module adder_8bits (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [8:0] carry;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_fa
            assign S[i]       = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = carry[8];

endmodule

module mult_8bits_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start; P holds last result
    // RUN   | one add/shift step per clock, 8 steps total
    // DONE  | one-cycle result pulse, then back to IDLE
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  m;
    logic [7:0]  acc;
    logic [7:0]  q;
    logic [2:0]  cnt;
    logic [7:0]  addend;
    logic [7:0]  sum;
    logic        cout;
    logic [15:0] shifted;

    assign addend = q[0] ? m : 8'h00;

    adder_8bits u_adder (
        .A    (acc),
        .B    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    // 17-bit {cout, sum, q} shifted right by one; the dropped bit is q[0]
    assign shifted = {cout, sum, q[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m     <= 8'h00;
            acc   <= 8'h00;
            q     <= 8'h00;
            cnt   <= 3'd0;
            P     <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= A;
                        q     <= B;
                        acc   <= 8'h00;
                        cnt   <= 3'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= shifted[15:8];
                    q   <= shifted[7:0];
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        P     <= shifted;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mult_8bits_seq.sv
// Directed bench for mult_8bits_seq: a cycle-level reference model checked every cycle,
// plus literal expectations on each directed operation.

module tb_mult_8bits_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    mult_8bits_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: elapsed cycles since acceptance, -1 when idle.
    int          m_t;
    logic [15:0] m_prod;
    logic [15:0] m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = -1;
            m_p = 16'h0000;
        end else if (m_t < 0) begin
            if (start === 1'b1) begin
                m_t    = 0;
                m_prod = 16'(A) * 16'(B);
            end
        end else if (m_t == 8) begin
            m_t = -1;
        end else begin
            m_t = m_t + 1;
            if (m_t == 8) m_p = m_prod;
        end
    end

    always @(negedge clk) begin
        chk("model_p", P, m_p);
        chk("model_busy", {15'd0, busy}, {15'd0, (m_t >= 0 && m_t < 8)});
        chk("model_done", {15'd0, done}, {15'd0, (m_t == 8)});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Pulse start for one cycle, then measure busy length, done, and P.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p);
        int bc;
        bit seen;
        bc   = 0;
        seen = 0;
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        chk("op_done_seen", {15'd0, seen}, 16'd1);
        chk("op_busy_len", 16'(bc), 16'd8);
        chk("op_product", P, exp_p);
        @(negedge clk);
        chk("op_done_width", {15'd0, done}, 16'd0);
        chk("op_p_hold", P, exp_p);
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
    endtask

    initial begin
        bit seen;
        int gap;
        int busy_seen;
        rst_n = 1'b0;
        start = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_p", P, 16'h0000);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        rst_n = 1'b1;

        // Idle with operands toggling: nothing may move.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            A = 8'(i * 37);
            B = 8'(~i);
        end
        chk("idle_p", P, 16'h0000);
        chk("idle_done", {15'd0, done}, 16'd0);

        run_op(8'h0D, 8'h0B, 16'h008F);
        run_op(8'hFF, 8'hFF, 16'hFE01);
        run_op(8'h00, 8'hFF, 16'h0000);
        run_op(8'h80, 8'h02, 16'h0100);

        // start held high: back-to-back operations 10 cycles apart.
        @(negedge clk);
        A     = 8'h12;
        B     = 8'h34;
        start = 1'b1;
        wait_done(seen);
        chk("held_first_seen", {15'd0, seen}, 16'd1);
        chk("held_first_p", P, 16'h03A8);
        A   = 8'hFF;
        B   = 8'h01;
        gap = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            gap++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        chk("held_second_seen", {15'd0, seen}, 16'd1);
        chk("held_gap", 16'(gap), 16'd10);
        chk("held_second_p", P, 16'h00FF);
        repeat (3) @(negedge clk);

        // start and operand changes during RUN are ignored.
        @(negedge clk);
        A     = 8'h05;
        B     = 8'h06;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A     = 8'hFF;
        B     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen);
        chk("ignore_seen", {15'd0, seen}, 16'd1);
        chk("ignore_p", P, 16'h001E);
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || done) busy_seen++;
        end
        chk("ignore_no_second", 16'(busy_seen), 16'd0);

        // Reset during the 4th step aborts with no done pulse.
        @(negedge clk);
        A     = 8'hAA;
        B     = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_p", P, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) busy_seen++;
        end
        chk("abort_no_done", 16'(busy_seen), 16'd0);

        run_op(8'h03, 8'h07, 16'h0015);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
